led_pattern_monitor: RTL and testbench



---
 rtl/led_pattern_monitor.sv | 186 ++++++++++++++++++
 tb/tb_led_pattern_monitor.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_monitor.sv
// LED bus pattern decoder: classifies each LED step, locks onto ROL/ROR/PINGPONG/BLINK
// and measures the step period. Define LED_MON_ERRCNT_EN to build the lock-loss counter.
module led_pattern_monitor #(
    parameter int unsigned         PERIOD_W    = 24,
    parameter int unsigned         LOCK_N      = 4,
    parameter logic [PERIOD_W-1:0] TIMEOUT     = 24'hFFFFFF,
    parameter logic [PERIOD_W-1:0] FAST_THRESH = 24'd1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [15:0]         led,
    output logic                locked,
    output logic [2:0]          pattern_id,
    output logic [PERIOD_W-1:0] step_period,
    output logic                speed_fast,
    output logic                change_pulse,
    output logic [7:0]          err_count
);

    typedef enum logic [1:0] {S_IDLE, S_ACQUIRE, S_LOCKED} state_t;
    typedef enum logic [1:0] {C_OTHER, C_ROL, C_ROR, C_BLINK} cls_t;

    localparam logic [2:0] PID_NONE     = 3'd0;
    localparam logic [2:0] PID_ROL      = 3'd1;
    localparam logic [2:0] PID_ROR      = 3'd2;
    localparam logic [2:0] PID_PINGPONG = 3'd3;
    localparam logic [2:0] PID_BLINK    = 3'd4;
    localparam logic [3:0] LOCK_M       = 4'(LOCK_N);

    state_t              state, state_n;
    cls_t                cand, cand_n, cls;
    logic [15:0]         led_q;
    logic                valid;
    logic [PERIOD_W-1:0] cnt;
    logic [3:0]          match, match_n, match_inc;
    logic                locked_n;
    logic [2:0]          pid_n;
    logic [PERIOD_W-1:0] period_n;
    logic                change, timeout_hit, accept, pingpong_flip;

    function automatic logic [2:0] cls_to_pid(cls_t c);
        case (c)
            C_ROL:   return PID_ROL;
            C_ROR:   return PID_ROR;
            C_BLINK: return PID_BLINK;
            default: return PID_NONE;
        endcase
    endfunction

    assign change      = valid && (led != led_q);
    assign timeout_hit = (cnt >= TIMEOUT);
    assign match_inc   = match + 4'd1;

    // Rotate checks come first, so 0x5555->0xAAAA reads as ROL rather than BLINK.
    always_comb begin
        cls = C_OTHER;
        if (led == {led_q[14:0], led_q[15]})
            cls = C_ROL;
        else if (led == {led_q[0], led_q[15:1]})
            cls = C_ROR;
        else if (led == ~led_q)
            cls = C_BLINK;
    end

    always_comb begin
        accept = 1'b0;
        case (pattern_id)
            PID_ROL, PID_ROR, PID_PINGPONG: accept = (cls == C_ROL) || (cls == C_ROR);
            PID_BLINK:                      accept = (cls == C_BLINK);
            default:                        accept = 1'b0;
        endcase
    end

    assign pingpong_flip = (pattern_id == PID_ROL && cls == C_ROR) ||
                           (pattern_id == PID_ROR && cls == C_ROL);

    always_comb begin
        state_n  = state;
        cand_n   = cand;
        match_n  = match;
        locked_n = locked;
        pid_n    = pattern_id;
        period_n = step_period;
        case (state)
            S_IDLE: begin
                // No previous change to measure against, so the period is left alone.
                if (change) begin
                    state_n = S_ACQUIRE;
                    cand_n  = cls;
                    match_n = 4'd1;
                end
            end
            S_ACQUIRE: begin
                if (change) begin
                    period_n = cnt;
                    if (cls == cand && cls != C_OTHER) begin
                        match_n = match_inc;
                        if (match_inc == LOCK_M) begin
                            state_n  = S_LOCKED;
                            locked_n = 1'b1;
                            pid_n    = cls_to_pid(cand);
                        end
                    end else begin
                        cand_n  = cls;
                        match_n = 4'd1;
                    end
                end else if (timeout_hit) begin
                    state_n  = S_IDLE;
                    locked_n = 1'b0;
                    pid_n    = PID_NONE;
                end
            end
            S_LOCKED: begin
                if (change) begin
                    period_n = cnt;
                    if (accept) begin
                        if (pingpong_flip)
                            pid_n = PID_PINGPONG;
                    end else begin
                        state_n  = S_ACQUIRE;
                        locked_n = 1'b0;
                        pid_n    = PID_NONE;
                        cand_n   = cls;
                        match_n  = 4'd1;
                    end
                end else if (timeout_hit) begin
                    state_n  = S_IDLE;
                    locked_n = 1'b0;
                    pid_n    = PID_NONE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q        <= '0;
            valid        <= 1'b0;
            cnt          <= '0;
            match        <= '0;
            cand         <= C_OTHER;
            state        <= S_IDLE;
            locked       <= 1'b0;
            pattern_id   <= PID_NONE;
            step_period  <= '0;
            speed_fast   <= 1'b0;
            change_pulse <= 1'b0;
        end else begin
            led_q <= led;
            valid <= 1'b1;
            if (change)
                cnt <= PERIOD_W'(1);
            else if (cnt != '1)
                cnt <= cnt + PERIOD_W'(1);
            state        <= state_n;
            cand         <= cand_n;
            match        <= match_n;
            locked       <= locked_n;
            pattern_id   <= pid_n;
            step_period  <= period_n;
            speed_fast   <= locked_n && (period_n < FAST_THRESH);
            change_pulse <= change;
        end
    end

`ifdef LED_MON_ERRCNT_EN
    // A loss is leaving LOCKED, either on a rejected step or on timeout.
    logic       loss;
    logic [7:0] err_q;

    assign loss = (state == S_LOCKED) && (change ? !accept : timeout_hit);

    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 8'd0;
        else if (loss && err_q != 8'hFF)
            err_q <= err_q + 8'd1;
    end

    assign err_count = err_q;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_led_pattern_monitor.sv
// Scoreboard bench for led_pattern_monitor: a reference model predicts the outputs of every
// LED change; a monitor pops and compares whenever change_pulse is seen.
module tb_led_pattern_monitor;

    localparam int PW     = 24;
    localparam int LOCK_N = 4;
    localparam int TMO    = 100;
    localparam int FT     = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   led = 16'h0000;
    logic          locked;
    logic [2:0]    pattern_id;
    logic [PW-1:0] step_period;
    logic          speed_fast;
    logic          change_pulse;
    logic [7:0]    err_count;

    led_pattern_monitor #(
        .PERIOD_W   (PW),
        .LOCK_N     (LOCK_N),
        .TIMEOUT    (24'd100),
        .FAST_THRESH(24'd20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .led         (led),
        .locked      (locked),
        .pattern_id  (pattern_id),
        .step_period (step_period),
        .speed_fast  (speed_fast),
        .change_pulse(change_pulse),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic          lk;
        logic [2:0]    pid;
        logic [PW-1:0] per;
        logic          fast;
        logic [7:0]    err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: the rules expressed as "how many same-kind steps in a row".
    bit          m_idle;
    bit          m_lock;
    int          m_pid;
    int          m_cls;
    int          m_run;
    int          m_per;
    int          m_errs;
    logic [15:0] m_prev;
    int          m_last_e;

    function automatic logic [15:0] rotl(logic [15:0] x);
        int ov = x;
        return 16'(((ov * 2) + (ov / 32768)) % 65536);
    endfunction

    function automatic logic [15:0] rotr(logic [15:0] x);
        int ov = x;
        return 16'((ov / 2) + (ov % 2) * 32768);
    endfunction

    // 0=other 1=rotate left 2=rotate right 3=invert
    function automatic int classify(logic [15:0] o, logic [15:0] n);
        if (n == rotl(o)) return 1;
        if (n == rotr(o)) return 2;
        if (n == ~o)      return 3;
        return 0;
    endfunction

    function automatic int exp_err();
`ifdef LED_MON_ERRCNT_EN
        return (m_errs > 255) ? 255 : m_errs;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset(input logic [15:0] l0);
        m_idle = 1; m_lock = 0; m_pid = 0; m_cls = 0; m_run = 0;
        m_per = 0; m_errs = 0; m_prev = l0; m_last_e = 0;
    endtask

    // Apply a timeout if edge e is at least TMO edges past the last change.
    task automatic model_expire(input int e);
        if (!m_idle && e >= m_last_e + TMO) begin
            if (m_lock) m_errs++;
            m_lock = 0;
            m_pid  = 0;
            m_idle = 1;
        end
    endtask

    task automatic model_change(input logic [15:0] v, input int e);
        int   c;
        int   ee;
        exp_t x;
        model_expire(e - 1);
        if (v == m_prev) return;
        c = classify(m_prev, v);
        m_prev = v;
        if (m_idle) begin
            m_idle = 0;
            m_cls  = c;
            m_run  = 1;
        end else begin
            m_per = e - m_last_e;
            if (m_lock) begin
                if ((m_pid inside {1, 2, 3}) && (c == 1 || c == 2)) begin
                    if (m_pid != 3 && c != m_pid) m_pid = 3;
                end else if (m_pid == 4 && c == 3) begin
                    m_pid = 4;
                end else begin
                    m_lock = 0; m_pid = 0; m_errs++;
                    m_cls = c; m_run = 1;
                end
            end else if (c == m_cls && c != 0) begin
                m_run++;
                if (m_run == LOCK_N) begin
                    m_lock = 1;
                    m_pid  = (c == 3) ? 4 : c;
                end
            end else begin
                m_cls = c;
                m_run = 1;
            end
        end
        m_last_e = e;
        ee     = exp_err();
        x.lk   = m_lock;
        x.pid  = m_pid[2:0];
        x.per  = m_per[PW-1:0];
        x.fast = m_lock && (m_per < FT);
        x.err  = ee[7:0];
        sb.push_back(x);
    endtask

    // Monitor: every change_pulse must match the oldest prediction.
    always @(negedge clk) begin
        if (!rst && change_pulse) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change: change_pulse with no predicted change (cycle %0d)", cyc);
            end else begin
                exp_t x;
                exp_t a;
                x = sb.pop_front();
                a = {locked, pattern_id, step_period, speed_fast, err_count};
                if (a !== x) begin
                    errors++;
                    $display("FAIL change_outputs: got lk=%0d pid=%0d per=%0d fast=%0d err=%0d expected lk=%0d pid=%0d per=%0d fast=%0d err=%0d (cycle %0d)",
                             a.lk, a.pid, a.per, a.fast, a.err, x.lk, x.pid, x.per, x.fast, x.err, cyc);
                end
            end
        end
    end

    // Called at a negedge: present v before the next posedge, then hold for gap cycles.
    task automatic step(input logic [15:0] v, input int gap);
        led = v;
        model_change(v, cyc + 1);
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_reset(input logic [15:0] l0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            led = (i % 2 == 1) ? 16'h00FF : 16'hFF00;
            @(negedge clk);
            check("reset_outputs", {locked, pattern_id, step_period, speed_fast, change_pulse, err_count}, 64'd0);
        end
        check("sb_drained_at_reset", sb.size(), 64'd0);
        sb.delete();
        led = l0;
        rst = 1'b0;
        model_reset(l0);
        @(negedge clk);
    endtask

    task automatic check_timeout(input string tag);
        int guard = 0;
        int ee;
        while (cyc < m_last_e + TMO - 1 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        model_expire(cyc);
        check({tag, "_before"}, {locked, pattern_id}, {m_lock, m_pid[2:0]});
        @(negedge clk);
        model_expire(cyc);
        ee = exp_err();
        check({tag, "_after"}, {locked, pattern_id, speed_fast, err_count},
              {m_lock, m_pid[2:0], 1'b0, ee[7:0]});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] v;
        model_reset(16'h0000);

        // Rotate left every 10 cycles from 0x0001, then reverse at 0x8000.
        do_reset(16'h0001);
        v = 16'h0001;
        for (int i = 0; i < 15; i++) begin
            v = rotl(v);
            step(v, 10);
        end
        step(16'h4000, 10);
        step(16'h2000, 10);
        step(16'h4000, 10);
        step(16'h8000, 10);
        step(16'h0001, 10);

        // Blink every 50 cycles.
        step(16'h0000, 50);
        for (int i = 0; i < 6; i++) step((i % 2 == 0) ? 16'hFFFF : 16'h0000, 50);

        // Lock on ROL, jump away, relock, then let it time out.
        step(16'h4000, 10);
        step(16'h8000, 10);
        step(16'h0001, 10);
        step(16'h0002, 10);
        step(16'h0004, 10);
        step(16'h0F0F, 10);
        step(16'h1E1E, 10);
        step(16'h3C3C, 10);
        step(16'h7878, 10);
        step(16'hF0F0, 10);
        check_timeout("timeout_locked");

        // Relock and reset in the middle of the lock.
        v = 16'hF0F0;
        for (int i = 0; i < 6; i++) begin
            v = rotr(v);
            step(v, 7);
        end
        do_reset(16'h0100);

        // Randomized episodes.
        v = 16'h0100;
        for (int ep = 0; ep < 40; ep++) begin
            int mode = $urandom_range(0, 4);
            int n    = $urandom_range(3, 10);
            int gap  = $urandom_range(1, 40);
            if ($urandom_range(0, 9) == 0) gap = $urandom_range(95, 110);
            if ($urandom_range(0, 11) == 0) begin
                v = 16'($urandom);
                do_reset(v);
            end
            if (mode <= 2 && (v == 16'h0000 || v == 16'hFFFF)) begin
                v = 16'($urandom_range(1, 16'hFFFE));
                step(v, gap);
            end
            for (int k = 0; k < n; k++) begin
                case (mode)
                    0:       v = rotl(v);
                    1:       v = rotr(v);
                    2:       v = ($urandom_range(0, 1) == 1) ? rotl(v) : rotr(v);
                    3:       v = ~v;
                    default: v = 16'($urandom);
                endcase
                step(v, gap);
            end
        end

        repeat (5) @(negedge clk);
        check("sb_empty_at_end", sb.size(), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
